// File: rtl/spiflash_read_ctrl.sv
// spiflash_read_ctrl: single-word SPI flash READ (0x03) sequencer, mode 0.
// Sends cmd+addr, clocks in 32 data bits, returns a little-endian word.
module spiflash_read_ctrl #(
  parameter int CLK_DIV    = 1,
  parameter int CSH_CYCLES = 2
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [21:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spiflash_cs_n,
  output logic        spiflash_clk,
  output logic        spiflash_mosi,
  input  logic        spiflash_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q;
  logic        sclk_q;
  logic [6:0]  bit_q;
  logic [31:0] sh_q;
  logic [31:0] rx_q;
  logic [3:0]  gap_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;

  logic accept;
  logic tick;
  logic rise;
  logic fall;
  logic last;

  assign accept = (state_q == IDLE) && req_valid;
  assign tick   = (state_q == SHIFT) && (div_q == 8'd0);
  assign rise   = tick && !sclk_q;
  assign fall   = tick && sclk_q;
  assign last   = fall && (bit_q == 7'd0);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = SHIFT;
      SHIFT: if (last) state_d = (CSH_CYCLES == 1) ? IDLE : DONE;
      DONE,
      GAP:   state_d = (gap_q <= 4'd1) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    busy          = 1'b1;
    spiflash_cs_n = 1'b1;
    spiflash_mosi = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SHIFT: begin
        spiflash_cs_n = 1'b0;
        spiflash_mosi = sh_q[31];
      end
      default: ;
    endcase
  end

  assign spiflash_clk = sclk_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

  // The first divider period is one cycle longer so the first rise lands
  // at T+1+CLK_DIV and the last fall at T+1+128*CLK_DIV.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      div_q       <= '0;
      sclk_q      <= 1'b0;
      bit_q       <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      gap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        sh_q   <= {8'h03, req_addr, 2'b00};
        bit_q  <= 7'd64;
        div_q  <= 8'(CLK_DIV);
        sclk_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (tick) begin
          div_q  <= 8'(CLK_DIV - 1);
          sclk_q <= !sclk_q;
        end else begin
          div_q <= div_q - 8'd1;
        end
        if (rise) begin
          rx_q  <= {rx_q[30:0], spiflash_miso};
          bit_q <= bit_q - 7'd1;
        end
        if (fall) sh_q <= {sh_q[30:0], 1'b0};
        if (last) begin
          gap_q       <= 4'(CSH_CYCLES - 1);
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= {rx_q[7:0], rx_q[15:8],
                          rx_q[23:16], rx_q[31:24]};
        end
      end else if (gap_q != 4'd0) begin
        gap_q <= gap_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_spiflash_read_ctrl.sv
// tb_spiflash_read_ctrl: two controllers (CLK_DIV 1/3) against a behavioural
// SPI flash built on a byte memory; words predicted from that memory.
module tb_spiflash_read_ctrl;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  busy;
  logic [1:0]  cs_n;
  logic [1:0]  sclk;
  logic [1:0]  mosi;
  logic [1:0]  miso;
  logic [21:0] req_addr [2];
  logic [31:0] rsp_data [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem [int];

  always #5 core_clk = ~core_clk;

  function automatic logic [7:0] fbyte(int a);
    int aa;
    aa = a & 32'h00FF_FFFF;
    if (mem.exists(aa)) return mem[aa];
    return 8'((aa * 29) ^ (aa >> 7) ^ 8'hA5);
  endfunction

  function automatic logic [31:0] exp_word(logic [21:0] addr);
    int b;
    b = int'({addr, 2'b00});
    return {fbyte(b + 3), fbyte(b + 2), fbyte(b + 1), fbyte(b)};
  endfunction

  function automatic int div_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    int          nrise = 0;
    logic [31:0] cap = '0;
    bit          mbad = 1'b0;
    int          l_rises = 0;
    logic [31:0] l_cap = '0;
    bit          l_mbad = 1'b0;
    logic        miso_r = 1'b0;
    int          i;
    logic [7:0]  b;

    assign miso[g] = miso_r;

    spiflash_read_ctrl #(
      .CLK_DIV   (g == 0 ? 1 : 3),
      .CSH_CYCLES(g == 0 ? 2 : 3)
    ) u_dut (
      .core_clk     (core_clk),
      .core_rst_n   (core_rst_n),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_addr     (req_addr[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_data     (rsp_data[g]),
      .busy         (busy[g]),
      .spiflash_cs_n(cs_n[g]),
      .spiflash_clk (sclk[g]),
      .spiflash_mosi(mosi[g]),
      .spiflash_miso(miso[g])
    );

    // Flash: latch cmd/addr on rises, drive data on falls, MSB first.
    always @(posedge sclk[g] or negedge sclk[g] or posedge cs_n[g]) begin
      if (cs_n[g] === 1'b1) begin
        if (nrise != 0) begin
          l_rises = nrise;
          l_cap   = cap;
          l_mbad  = mbad;
        end
        nrise  = 0;
        cap    = '0;
        mbad   = 1'b0;
        miso_r = 1'b0;
      end else if (cs_n[g] === 1'b0 && sclk[g] === 1'b1) begin
        if (nrise < 32) cap = {cap[30:0], mosi[g]};
        else if (mosi[g] !== 1'b0) mbad = 1'b1;
        nrise++;
      end else if (cs_n[g] === 1'b0 && nrise >= 32 && nrise < 64) begin
        i      = nrise - 32;
        b      = fbyte(int'(cap[23:0]) + i / 8);
        miso_r = b[7 - (i % 8)];
      end
    end
  end

  function automatic int get_rises(int g);
    return (g == 0) ? gd[0].l_rises : gd[1].l_rises;
  endfunction

  function automatic logic [31:0] get_cap(int g);
    return (g == 0) ? gd[0].l_cap : gd[1].l_cap;
  endfunction

  function automatic bit get_mbad(int g);
    return (g == 0) ? gd[0].l_mbad : gd[1].l_mbad;
  endfunction

  // Issues one read; reports word, latency, first SCLK rise and T+1 status.
  task automatic do_read(input int g, input logic [21:0] addr,
                         input bit scramble, output logic [31:0] data,
                         output int lat, output int first_rise,
                         output logic [2:0] st1);
    int budget;
    data       = 'x;
    lat        = -1;
    first_rise = -1;
    budget     = 0;
    while (req_ready[g] !== 1'b1 && budget < 1000) begin
      @(negedge core_clk);
      budget++;
    end
    req_addr[g]  = addr;
    req_valid[g] = 1'b1;
    @(negedge core_clk);
    req_valid[g] = 1'b0;
    st1 = {req_ready[g], busy[g], cs_n[g]};
    for (int c = 1; c <= 200 * div_of(g) + 50; c++) begin
      @(negedge core_clk);
      if (scramble) req_addr[g] = 22'($urandom);
      if (sclk[g] === 1'b1 && first_rise < 0) first_rise = c;
      if (rsp_valid[g] === 1'b1) begin
        lat  = c;
        data = rsp_data[g];
        break;
      end
    end
  endtask

  task automatic test_reset();
    core_rst_n = 1'b0;
    repeat (3) @(negedge core_clk);
    core_rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (rsp_data[g] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rsp_data[%0d]: got %h want 0", g, rsp_data[g]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge core_clk);
      for (int g = 0; g < 2; g++) begin
        n_checks++;
        if ({cs_n[g], sclk[g], mosi[g], req_ready[g], rsp_valid[g], busy[g]}
            !== 6'b100100) begin
          n_fail++;
          $display("FAIL idle[%0d] cyc %0d: got %b want 100100", g, c,
                   {cs_n[g], sclk[g], mosi[g], req_ready[g], rsp_valid[g],
                    busy[g]});
        end
      end
    end
  endtask

  task automatic test_known_words();
    logic [31:0] d;
    int lat, fr;
    logic [2:0] st;
    mem[0] = 8'h6F; mem[1] = 8'h00; mem[2] = 8'h40; mem[3] = 8'h0B;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05;
    mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
    do_read(0, 22'h0, 1'b0, d, lat, fr, st);
    n_checks++;
    if (d !== 32'h0B40006F) begin
      n_fail++; $display("FAIL word0_data: got %h want 0b40006f", d);
    end
    n_checks++;
    if (lat !== 129) begin
      n_fail++; $display("FAIL word0_latency: got %0d want 129", lat);
    end
    n_checks++;
    if (fr !== 2) begin
      n_fail++; $display("FAIL word0_first_rise: got %0d want 2", fr);
    end
    n_checks++;
    if (st !== 3'b010) begin
      n_fail++; $display("FAIL word0_t1_status: got %b want 010", st);
    end
    @(negedge core_clk);
    n_checks++;
    if (rsp_valid[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL word0_pulse: got valid=%b cs_n=%b want 0 1",
               rsp_valid[0], cs_n[0]);
    end
    n_checks++;
    if (get_rises(0) !== 64 || get_cap(0) !== 32'h03000000
        || get_mbad(0) !== 1'b0) begin
      n_fail++;
      $display("FAIL word0_bus: got rises=%0d cmdaddr=%h mbad=%b want 64 03000000 0",
               get_rises(0), get_cap(0), get_mbad(0));
    end
    do_read(1, 22'h40, 1'b0, d, lat, fr, st);
    n_checks++;
    if (d !== 32'h00100513) begin
      n_fail++; $display("FAIL word100_data: got %h want 00100513", d);
    end
    n_checks++;
    if (lat !== 385) begin
      n_fail++; $display("FAIL word100_latency: got %0d want 385", lat);
    end
    n_checks++;
    if (fr !== 4) begin
      n_fail++; $display("FAIL word100_first_rise: got %0d want 4", fr);
    end
    n_checks++;
    if (get_rises(1) !== 64 || get_cap(1) !== 32'h03000100) begin
      n_fail++;
      $display("FAIL word100_bus: got rises=%0d cmdaddr=%h want 64 03000100",
               get_rises(1), get_cap(1));
    end
  endtask

  task automatic test_random(input int n, input bit scramble);
    logic [31:0] d;
    logic [21:0] a;
    int lat, fr, g;
    logic [2:0] st;
    for (int k = 0; k < n; k++) begin
      g = int'($urandom_range(1, 0));
      a = 22'($urandom);
      if (k == 0 && !scramble) a = 22'h3FFFFF;
      do_read(g, a, scramble, d, lat, fr, st);
      n_checks++;
      if (d !== exp_word(a)) begin
        n_fail++;
        $display("FAIL rand_data[%0d] addr %h: got %h want %h", g, a, d,
                 exp_word(a));
      end
      n_checks++;
      if (lat !== 1 + 128 * div_of(g)) begin
        n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d want %0d", g, lat,
                 1 + 128 * div_of(g));
      end
      n_checks++;
      if (get_cap(g) !== {8'h03, a, 2'b00} || get_rises(g) !== 64
          || get_mbad(g) !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: got cmdaddr=%h rises=%0d mbad=%b want %h 64 0",
                 g, get_cap(g), get_rises(g), get_mbad(g), {8'h03, a, 2'b00});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] a [3];
    logic [31:0] d [3];
    int tp [3];
    int runs [$];
    int k, run, budget;
    k = 0;
    run = 0;
    budget = 0;
    for (int i = 0; i < 3; i++) a[i] = 22'($urandom);
    while (req_ready[0] !== 1'b1 && budget < 1000) begin
      @(negedge core_clk);
      budget++;
    end
    req_addr[0]  = a[0];
    req_valid[0] = 1'b1;
    for (int c = 1; c < 3 * 131 + 50 && k < 3; c++) begin
      @(negedge core_clk);
      if (cs_n[0] === 1'b1) begin
        run++;
      end else begin
        if (k > 0 && run > 0) runs.push_back(run);
        run = 0;
      end
      if (rsp_valid[0] === 1'b1) begin
        d[k]  = rsp_data[0];
        tp[k] = c;
        k++;
        if (k < 3) req_addr[0] = a[k];
        else       req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    n_checks++;
    if (k !== 3) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 3", k);
    end
    for (int i = 0; i < k; i++) begin
      n_checks++;
      if (d[i] !== exp_word(a[i])) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, d[i], exp_word(a[i]));
      end
    end
    for (int i = 1; i < k; i++) begin
      n_checks++;
      if (tp[i] - tp[i-1] !== 131) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 131", i, tp[i] - tp[i-1]);
      end
    end
    n_checks++;
    if (runs.size() !== 2) begin
      n_fail++; $display("FAIL b2b_gap_count: got %0d want 2", runs.size());
    end
    foreach (runs[i]) begin
      n_checks++;
      if (runs[i] !== 2) begin
        n_fail++; $display("FAIL b2b_csn_high[%0d]: got %0d want 2", i, runs[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic [21:0] a;
    int lat, fr, spurious, budget;
    logic [2:0] st;
    spurious = 0;
    budget   = 0;
    while (req_ready[0] !== 1'b1 && budget < 1000) begin
      @(negedge core_clk);
      budget++;
    end
    req_addr[0]  = 22'($urandom);
    req_valid[0] = 1'b1;
    @(negedge core_clk);
    req_valid[0] = 1'b0;
    repeat (40) @(negedge core_clk);
    #2 core_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n[0], sclk[0], mosi[0], req_ready[0], busy[0]} !== 5'b10010) begin
      n_fail++;
      $display("FAIL abort_pins: got %b want 10010",
               {cs_n[0], sclk[0], mosi[0], req_ready[0], busy[0]});
    end
    repeat (3) begin
      @(negedge core_clk);
      if (rsp_valid[0] !== 1'b0) spurious++;
    end
    core_rst_n = 1'b1;
    repeat (200) begin
      @(negedge core_clk);
      if (rsp_valid[0] !== 1'b0 || cs_n[0] !== 1'b1) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d events want 0", spurious);
    end
    a = 22'($urandom);
    do_read(0, a, 1'b0, d, lat, fr, st);
    n_checks++;
    if (d !== exp_word(a) || lat !== 129) begin
      n_fail++;
      $display("FAIL abort_recover: got %h lat %0d want %h lat 129", d, lat,
               exp_word(a));
    end
  endtask

  initial begin
    req_valid   = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    test_reset();
    test_known_words();
    test_random(6, 1'b0);
    test_random(3, 1'b1);
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spiflash_read_ctrl.md
Name: spiflash_read_ctrl

Overview:
Single-port SPI flash read sequencer for the management SoC boot/execute path. Accepts word-aligned read requests from the core-side fetch/bus adapter and issues a standard READ (0x03) transaction to the external spiflash: 8-bit command, 24-bit address, 32 data bits. It returns one 32-bit little-endian word per request. It owns the spiflash_cs_n, spiflash_clk and spiflash_mosi pins and samples spiflash_miso.

Parameters:
CLK_DIV, 1, SCLK half-period in core_clk cycles; legal range 1..255.
CSH_CYCLES, 2, minimum cs_n high time in core_clk cycles between transactions; legal range 1..15.

Ports:
core_clk  input  1  system clock; all logic is on the rising edge.
core_rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  read request valid.
req_ready  output  1  controller can accept a request.
req_addr  input  22  word address; flash byte address is {req_addr,2'b00}.
rsp_valid  output  1  one-cycle pulse: rsp_data is valid.
rsp_data  output  32  read word; the first flash byte is placed in [7:0].
busy  output  1  high from acceptance until req_ready reasserts.
spiflash_cs_n  output  1  flash chip select, active low.
spiflash_clk  output  1  SPI clock, mode 0.
spiflash_mosi  output  1  serial data to flash, MSB first.
spiflash_miso  input  1  serial data from flash.

Behaviour:
- Reset, asynchronous, and on every return to IDLE:
  - req_ready=1, rsp_valid=0, rsp_data=0 (rsp_data is reset only), busy=0.
  - spiflash_cs_n=1, spiflash_clk=0, spiflash_mosi=0.
  - Reset mid-transaction aborts immediately. cs_n goes high and clk goes low in the same instant. No rsp_valid is generated.
- States: IDLE -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE:
  - req_ready=1.
  - Acceptance occurs at the edge T where req_valid&req_ready.
  - At T, the controller latches a 32-bit shift register = {8'h03, req_addr, 2'b00} and loads the bit counter with 64.
  - Next state is SHIFT. req_ready=0 and busy=1 from T+1.
- SHIFT:
  - cs_n=0 from T+1.
  - mosi carries shifter[31] from T+1.
  - A divider counter toggles spiflash_clk every CLK_DIV cycles; the first rise is at T+1+CLK_DIV.
  - On each core_clk edge that drives spiflash_clk 0->1, the controller samples miso into the receive register and decrements the bit counter.
  - On each 1->0 edge, the shifter shifts left and mosi updates. After 32 bits have been sent, mosi=0.
  - Exactly 64 SCLK rising edges occur per transaction.
  - rsp_data is assembled byte-wise: the first received byte goes to [7:0] and the fourth to [31:24]. Within each byte, the first bit received is bit 7.
- DONE:
  - On the falling SCLK edge after the 64th rise (edge T+1+128*CLK_DIV), cs_n=1 and clk=0.
  - rsp_valid=1 for exactly that one cycle, with rsp_data updated on the same edge.
  - rsp_data holds its value until the next response.
- GAP:
  - cs_n stays high for CSH_CYCLES cycles in total, counting from the cs_n rising edge.
  - req_ready=1 and busy=0 on the edge after those cycles. req_valid is ignored until then.
- Latency, acceptance to rsp_valid: 1+128*CLK_DIV cycles (129 for CLK_DIV=1).
- Back-to-back throughput: one word per 1+128*CLK_DIV+CSH_CYCLES cycles.
- Handshake rules:
  - No back-pressure on the response side; the consumer must take rsp_valid when it pulses.
  - req_addr is sampled only at acceptance; changes afterwards have no effect.
  - req_valid held high through the whole transaction is not a second request until req_ready=1.
- Boundary: req_addr=22'h3FFFFF sends address 0xFFFFFC. The controller does no wrap handling; the flash device defines the wrap.

Test Plan:
- Reset, then idle 20 cycles -> cs_n=1, clk=0, mosi=0, req_ready=1, rsp_valid=0, busy=0 throughout.
- Flash bytes 00..03 = 6F 00 40 0B; req_addr=0 with CLK_DIV=1 -> mosi bits 0x03,0x000000; rsp_valid exactly 129 cycles after acceptance; rsp_data=0x0B40006F; exactly 64 SCLK rises.
- Bytes 0x100..0x103 = 13 05 10 00; req_addr=22'h40 with CLK_DIV=3 -> address bits 0x000100; rsp_valid 385 cycles after acceptance; rsp_data=0x00100513.
- req_valid held high for 3 consecutive requests with CLK_DIV=1, CSH_CYCLES=2 -> 3 rsp_valid pulses 131 cycles apart; cs_n high for exactly 2 cycles between transactions.
- core_rst_n pulled low 40 cycles into a transaction -> cs_n=1 and clk=0 immediately; no rsp_valid. A fresh request after reset returns the correct word.
- req_addr changed every cycle after acceptance -> returned word matches the address latched at acceptance.
